// File: rtl/vga_scene_sequencer.sv
// rtl/vga_scene_sequencer.sv - frame-synchronous scene, animation and fade sequencer
//
// Purpose: owns the scene index, animation counter and 4-level fade for the VGA
// pattern datapath. A scene change runs fade out, switch, fade in, one step per
// frame. It is triggered by a button edge or by the auto-advance timeout.
//
// Ports:
//   clk, rst_n     pixel clock, asynchronous active-low reset
//   frame_start    1-cycle strobe per frame; all sequencing happens on it
//   btn_next       pre-synchronised button level; rising edges are detected here
//   pause          freezes the animation counter and the auto-advance timer
//   auto_en        enables auto-advance every FRAMES_PER_SCENE frames
//   speed          animation step = 1 << speed
//   reverse        animation counter counts down
//   scene          current scene index
//   anim_cnt       animation counter
//   fade           attenuation, 0 = full brightness, 3 = black
//   busy           a scene transition is in progress
module vga_scene_sequencer #(
    parameter int NUM_SCENES       = 4,
    parameter int FRAMES_PER_SCENE = 240,
    parameter int CNT_W            = 10,
    localparam int SCENE_W         = $clog2(NUM_SCENES),
    localparam int TIMER_W         = $clog2(FRAMES_PER_SCENE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               btn_next,
    input  logic               pause,
    input  logic               auto_en,
    input  logic [1:0]         speed,
    input  logic               reverse,
    output logic [SCENE_W-1:0] scene,
    output logic [CNT_W-1:0]   anim_cnt,
    output logic [1:0]         fade,
    output logic               busy
);

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [SCENE_W-1:0] r_scene;
    logic [CNT_W-1:0]   r_anim_cnt;
    logic [1:0]         r_fade;
    logic [TIMER_W-1:0] r_timer;
    logic               r_next_req;
    logic               r_btn_d;

    state_t             w_state_nxt;
    logic [SCENE_W-1:0] w_scene_nxt;
    logic [CNT_W-1:0]   w_anim_nxt;
    logic [1:0]         w_fade_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_req_nxt;

    logic               w_btn_rise;
    logic               w_req_pend;
    logic               w_timeout;
    logic               w_run;
    logic [CNT_W-1:0]   w_step;

    assign w_btn_rise = btn_next & ~r_btn_d;
    // An edge is only accepted while playing; the same-cycle edge is folded in so a
    // press coinciding with frame_start starts the transition on that frame.
    assign w_req_pend = r_next_req | (w_btn_rise & (r_state == PLAY));
    assign w_run      = auto_en & ~pause;
    assign w_timeout  = w_run & (r_timer == TIMER_W'(FRAMES_PER_SCENE - 1));
    assign w_step     = CNT_W'(1) << speed;

    always_comb begin
        w_state_nxt = r_state;
        w_scene_nxt = r_scene;
        w_anim_nxt  = r_anim_cnt;
        w_fade_nxt  = r_fade;
        w_timer_nxt = r_timer;
        w_req_nxt   = w_req_pend;

        if (frame_start) begin
            if (!pause) begin
                w_anim_nxt = reverse ? (r_anim_cnt - w_step) : (r_anim_cnt + w_step);
            end

            case (r_state)
                PLAY: begin
                    if (w_req_pend || w_timeout) begin
                        w_state_nxt = FADE_OUT;
                        w_fade_nxt  = 2'd1;
                        w_req_nxt   = 1'b0;
                        w_timer_nxt = '0;
                    end else if (w_run) begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
                FADE_OUT: begin
                    if (r_fade == 2'd3) begin
                        // Screen is black: switch scene and restart the animation.
                        w_scene_nxt = (r_scene == SCENE_W'(NUM_SCENES - 1)) ?
                                      '0 : (r_scene + SCENE_W'(1));
                        w_anim_nxt  = '0;
                        w_state_nxt = FADE_IN;
                    end else begin
                        w_fade_nxt = r_fade + 2'd1;
                    end
                end
                FADE_IN: begin
                    w_fade_nxt = r_fade - 2'd1;
                    if (r_fade == 2'd1) begin
                        w_state_nxt = PLAY;
                    end
                end
                default: begin
                    w_state_nxt = PLAY;
                    w_fade_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PLAY;
            r_scene    <= '0;
            r_anim_cnt <= '0;
            r_fade     <= 2'd0;
            r_timer    <= '0;
            r_next_req <= 1'b0;
            r_btn_d    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_scene    <= w_scene_nxt;
            r_anim_cnt <= w_anim_nxt;
            r_fade     <= w_fade_nxt;
            r_timer    <= w_timer_nxt;
            r_next_req <= w_req_nxt;
            r_btn_d    <= btn_next;
        end
    end

    assign scene    = r_scene;
    assign anim_cnt = r_anim_cnt;
    assign fade     = r_fade;
    assign busy     = (r_state != PLAY);

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// tb/tb_vga_scene_sequencer.sv - self-checking bench for vga_scene_sequencer
module tb_vga_scene_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       btn_next;
    logic       pause;
    logic       auto_en;
    logic [1:0] speed;
    logic       reverse;
    logic [1:0] scene;
    logic [9:0] anim_cnt;
    logic [1:0] fade;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a transition is a step count 0..6 (0 = playing).
    int m_scene, m_anim, m_step, m_timer;
    bit m_pend, m_prev;
    int fade_of [7] = '{0, 1, 2, 3, 3, 2, 1};

    always #5 clk = ~clk;

    vga_scene_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_next    (btn_next),
        .pause       (pause),
        .auto_en     (auto_en),
        .speed       (speed),
        .reverse     (reverse),
        .scene       (scene),
        .anim_cnt    (anim_cnt),
        .fade        (fade),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_scene = 0; m_anim = 0; m_step = 0; m_timer = 0; m_pend = 0; m_prev = 0;
    endtask

    task automatic model_update(input bit fs, input bit b);
        int d;
        if (b && !m_prev && m_step == 0) m_pend = 1;
        m_prev = b;
        if (fs) begin
            d = 1 << speed;
            if (reverse) d = -d;
            if (m_step == 3) m_anim = 0;
            else if (!pause) m_anim = ((m_anim + d) % 1024 + 1024) % 1024;
            if (m_step == 0) begin
                if (m_pend || (auto_en && !pause && m_timer == 239)) begin
                    m_step = 1; m_pend = 0; m_timer = 0;
                end else if (auto_en && !pause) begin
                    m_timer++;
                end
            end else begin
                m_step++;
                if (m_step == 4) m_scene = (m_scene + 1) % 4;
                if (m_step == 7) m_step = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("scene", 32'(scene), 32'(m_scene));
        chk("anim_cnt", 32'(anim_cnt), 32'(m_anim));
        chk("fade", 32'(fade), 32'(fade_of[m_step]));
        chk("busy", 32'(busy), 32'(m_step != 0));
    endtask

    // Called at a negedge: drive, let one posedge happen, compare at the next negedge.
    task automatic cyc(input bit fs, input bit b);
        frame_start = fs;
        btn_next    = b;
        @(posedge clk);
        model_update(fs, b);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic frame(input int idle);
        for (int i = 0; i < idle; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic pulse();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        int exp_fade [7] = '{1, 2, 3, 3, 2, 1, 0};
        int a0, s0, k;
        rst_n = 1'b0; frame_start = 1'b0; btn_next = 1'b0;
        pause = 1'b0; auto_en = 1'b0; speed = 2'd0; reverse = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Counter up then down through the wrap.
        speed = 2'd2;
        for (int i = 0; i < 3; i++) frame(1);
        chk("cnt_up_12", 32'(anim_cnt), 32'd12);
        reverse = 1'b1; speed = 2'd0;
        for (int i = 0; i < 13; i++) frame(0);
        chk("cnt_wrap_1023", 32'(anim_cnt), 32'd1023);
        reverse = 1'b0;

        // Button transition, step by step.
        pulse();
        for (int i = 0; i < 7; i++) begin
            frame(1);
            chk("btn_fade", 32'(fade), 32'(exp_fade[i]));
            chk("btn_busy", 32'(busy), 32'(i < 6));
            chk("btn_scene", 32'(scene), 32'(i >= 3));
        end

        // Asynchronous reset in the middle of a fade-out.
        pulse();
        frame(0);
        frame(0);
        chk("pre_rst_fade", 32'(fade), 32'd2);
        chk("pre_rst_scene", 32'(scene), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_scene", 32'(scene), 32'd0);
        chk("rst_fade", 32'(fade), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_anim", 32'(anim_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Several edges in one frame give one transition; an edge in FADE_IN is dropped.
        pulse(); pulse(); pulse();
        for (int i = 0; i < 7; i++) frame(0);
        chk("multi_edge_scene", 32'(scene), 32'd1);
        pulse();
        for (int i = 0; i < 5; i++) frame(0);
        pulse();
        frame(0); frame(0);
        for (int i = 0; i < 10; i++) frame(0);
        chk("fadein_edge_dropped", 32'(busy), 32'd0);
        chk("fadein_edge_scene", 32'(scene), 32'd2);

        // Same-cycle edge and frame_start.
        cyc(1'b1, 1'b1);
        chk("same_cycle_edge", 32'(busy), 32'd1);
        btn_next = 1'b0;
        for (int i = 0; i < 6; i++) frame(0);

        // Pause freezes the counter but not transitions.
        speed = 2'd1; pause = 1'b1;
        a0 = int'(anim_cnt);
        for (int i = 0; i < 10; i++) frame(0);
        chk("pause_hold", 32'(anim_cnt), 32'(a0));
        s0 = int'(scene);
        pulse();
        for (int i = 0; i < 7; i++) frame(0);
        chk("pause_trans_busy", 32'(busy), 32'd0);
        chk("pause_trans_scene", 32'(scene), 32'((s0 + 1) % 4));
        chk("pause_trans_anim", 32'(anim_cnt), 32'd0);
        pause = 1'b0;

        // Auto-advance after 240 frames.
        auto_en = 1'b1;
        k = 0;
        while (k < 300) begin
            k++;
            frame(0);
            if (busy) break;
        end
        chk("auto_240", 32'(k), 32'd240);
        for (int i = 0; i < 6; i++) frame(0);

        // Reach scene 3, then auto with a hold window, wrapping to scene 0.
        auto_en = 1'b0;
        for (int j = 0; j < 4 && m_scene != 3; j++) begin
            pulse();
            for (int i = 0; i < 7; i++) frame(0);
        end
        auto_en = 1'b1;
        for (int i = 0; i < 100; i++) frame(0);
        auto_en = 1'b0;
        for (int i = 0; i < 20; i++) frame(0);
        auto_en = 1'b1;
        k = 0;
        while (k < 300) begin
            k++;
            frame(0);
            if (busy) break;
        end
        chk("auto_hold_140", 32'(k), 32'd140);
        for (int i = 0; i < 6; i++) frame(0);
        chk("auto_wrap_scene", 32'(scene), 32'd0);

        // Randomised stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                pause   = ($urandom_range(0, 3) == 0);
                auto_en = $urandom_range(0, 1);
                speed   = 2'($urandom_range(0, 3));
                reverse = $urandom_range(0, 1);
            end
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
